// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Brief    : Shared constants and types for the iterative RV32M unit
//             (op encodings, FSM states, special-case results).
//  Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    SIGNFIX = 2'd2,
    DONE    = 2'd3
  } mdu_state_t;

  // Architected results for the cases that never enter the iteration loop
  localparam logic [MDU_XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [MDU_XLEN-1:0] OVF_QUOT  = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_div_step
//  Brief    : One restoring-division iteration: shifts the next dividend bit
//             into the partial remainder and subtracts the divisor if it fits.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_dvd_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // The incoming remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the top bit of the difference is a clean
  // borrow flag.
  assign o_qbit  = ~w_diff[XLEN];
  assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Brief    : Iterative RV32M multiply/divide unit with valid/ready write-back.
//             Shift-add multiply and restoring divide, one bit per cycle, on
//             operand magnitudes with a final sign-fix cycle.
//             Build option MDU_FAST_MUL_EN: single-cycle combinational multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_wb_ready,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [4:0]       r_rd_addr;
  logic [XLEN-1:0]  r_hi;      // product high word / partial remainder
  logic [XLEN-1:0]  r_lo;      // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0]  r_b;       // multiplicand / divisor magnitude
  logic [XLEN-1:0]  r_result;
  logic             r_neg_lo;  // negate product or quotient
  logic             r_neg_hi;  // negate remainder

  // ---------------- operand decode at accept ----------------
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_accept   = i_valid & (r_state == IDLE) & ~i_flush;
  assign w_is_div   = i_op[2];
  assign w_a_signed = (i_op == MDU_MUL) | (i_op == MDU_MULH) | (i_op == MDU_MULHSU) |
                      (i_op == MDU_DIV) | (i_op == MDU_REM);
  assign w_b_signed = (i_op == MDU_MUL) | (i_op == MDU_MULH) |
                      (i_op == MDU_DIV) | (i_op == MDU_REM);
  assign w_a_neg    = w_a_signed & i_rs1_data[XLEN-1];
  assign w_b_neg    = w_b_signed & i_rs2_data[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_b_mag    = w_b_neg ? -i_rs2_data : i_rs2_data;
  assign w_div0     = w_is_div & (i_rs2_data == '0);
  assign w_ovf      = ((i_op == MDU_DIV) | (i_op == MDU_REM)) &
                      (i_rs1_data == OVF_QUOT) & (i_rs2_data == '1);

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN-1:0] w_fp;

  assign w_fa      = {w_a_signed & i_rs1_data[XLEN-1], i_rs1_data};
  assign w_fb      = {w_b_signed & i_rs2_data[XLEN-1], i_rs2_data};
  assign w_fp      = (2*XLEN)'(w_fa) * (2*XLEN)'(w_fb);
  assign w_special = w_div0 | w_ovf | ~w_is_div;
`else
  assign w_special = w_div0 | w_ovf;
`endif

  // Result for operations that skip the iteration loop
  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = i_op[1] ? i_rs1_data : DIV0_QUOT;
    end else if (w_ovf) begin
      w_special_res = i_op[1] ? '0 : OVF_QUOT;
    end
`ifdef MDU_FAST_MUL_EN
    else if (!w_is_div) begin
      w_special_res = (i_op == MDU_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
    end
`endif
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_div_rem;
  logic            w_qbit;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});

  mdu_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .i_rem     (r_hi),
    .i_dvd_bit (r_lo[XLEN-1]),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_qbit    (w_qbit)
  );

  // ---------------- sign fix / word select ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
  assign w_quot   = r_neg_lo ? -r_lo : r_lo;
  assign w_rem    = r_neg_hi ? -r_hi : r_hi;

  // Pick the architected word for the latched op
  always_comb begin
    w_fix_res = '0;
    case (r_op)
      MDU_MUL:                       w_fix_res = w_prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:             w_fix_res = w_quot;
      MDU_REM, MDU_REMU:             w_fix_res = w_rem;
      default:                       w_fix_res = '0;
    endcase
  end

  // ---------------- control FSM ----------------
  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CNT_W'(XLEN-1)) begin
          w_state_nxt = SIGNFIX;
        end
      end
      SIGNFIX: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_wb_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = IDLE;
    end
  end

  // Operand capture, per-cycle iteration and final result capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_rd_addr <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= i_op;
      r_rd_addr <= i_rd_addr;
      r_hi      <= '0;
      r_lo      <= w_a_mag;
      r_b       <= w_b_mag;
      r_neg_lo  <= w_a_neg ^ w_b_neg;
      r_neg_hi  <= w_a_neg;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (!i_flush && r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op[2]) begin
        r_hi <= w_div_rem;
        r_lo <= {r_lo[XLEN-2:0], w_qbit};
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (!i_flush && r_state == SIGNFIX) begin
      r_result <= w_fix_res;
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_rd_data = r_result;
  assign o_rd_wren = o_valid & i_wb_ready & ~i_flush & (r_rd_addr != 5'd0);

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit.
- Accepts one operation from the execute stage, computes the result over multiple cycles, and presents it on a write-back port that drives the register file write interface (rd address, rd data, write enable).
- The write-back port uses a valid/ready handshake so the pipeline's write-back arbiter can hold the result until the register file write port is free.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operation request.
- o_ready  out  1  unit can accept; high only in IDLE.
- i_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1_data  in  32  operand A.
- i_rs2_data  in  32  operand B.
- i_rd_addr  in  5  destination register.
- i_flush  in  1  kill any in-flight or pending operation.
- o_valid  out  1  result pending on the write-back port.
- i_wb_ready  in  1  write-back arbiter accepts the result this cycle.
- o_rd_addr  out  5  destination of the result.
- o_rd_data  out  32  result.
- o_rd_wren  out  1  o_valid AND i_wb_ready AND (o_rd_addr != 0); connects to the register file write enable.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_ready=1; o_valid=0; o_rd_wren=0; o_rd_addr=0; o_rd_data=0; counter and all datapath registers 0.
- States and transitions:
  - IDLE: on i_valid && o_ready, latch operands, op and rd_addr. Go to DONE if the op is a special case, else go to CALC with counter=0.
  - CALC: perform one iteration per cycle. Counter increments; after iteration XLEN-1 (counter==31), go to SIGNFIX.
  - SIGNFIX: one cycle; apply sign correction, select the hi/lo or quotient/remainder word, go to DONE.
  - DONE: o_valid=1. When i_wb_ready=1, go to IDLE (o_valid=0 next cycle).
- Latency from accept edge to o_valid=1: normal ops 34 cycles (1 setup + 32 CALC + 1 SIGNFIX); special cases 1 cycle.
- Multiply: operands converted to magnitudes per signedness (MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned). 64-bit shift-add, one bit per cycle. The 64-bit product is negated in SIGNFIX if the result sign is negative. MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- Divide: restoring divide on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A). Signed ops only.
- Special cases (bypass CALC, result in 1 cycle):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Output stability: o_rd_addr and o_rd_data are stable while o_valid=1 and i_wb_ready=0.
- Destination x0: computed normally and handshaken normally; o_rd_wren stays 0.
- i_flush (synchronous, any state): next state IDLE, o_valid=0; no write occurs even if i_wb_ready=1 in the same cycle. Flush has priority over accept and over the handshake.
- Simultaneous events: i_valid in any state other than IDLE is ignored (o_ready=0); the upstream stage stalls. No back-to-back accept in the cycle a DONE result retires; the next accept is possible one cycle later.
- Reset asserted mid-operation: immediate abort to the reset values above; no partial write.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: multiply ops use a single combinational 33x33 signed multiplier and go IDLE→DONE in 1 cycle. Divide is unchanged.
- Undefined: multiply is iterative with 34-cycle latency, as above.

Decomposition:
- Package mdu_pkg:
  - op encodings (MDU_MUL..MDU_REMU);
  - state enum (IDLE, CALC, SIGNFIX, DONE);
  - XLEN constant;
  - special-case constants (DIV0_QUOT=0xFFFFFFFF, OVF_QUOT=0x80000000).
- Sub-module mdu_div_step: combinational one-iteration restoring divide step (partial remainder, divisor in → next remainder, quotient bit out). It is shared by every CALC cycle for divide ops.

Test Plan:
- MUL A=7, B=-3, i_wb_ready=1, rd=5 → o_valid 34 cycles after accept; o_rd_data=0xFFFFFFEB, o_rd_wren=1 for one cycle, o_rd_addr=5.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=-1, B=0xFFFFFFFF → 0xFFFFFFFF. MULH A=0x80000000, B=0x80000000 → 0x40000000.
- DIV A=-7, B=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU A=100, B=0 → 0xFFFFFFFF after 1 cycle; REMU A=100, B=0 → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Hold i_wb_ready=0 for 5 cycles after o_valid → o_valid, o_rd_addr and o_rd_data stable, o_ready=0, a new i_valid is ignored. Then i_wb_ready=1 → one o_rd_wren pulse, o_ready=1 next cycle.
- i_flush at CALC cycle 10, and again in DONE with i_wb_ready=1 → no o_rd_wren, IDLE next cycle. i_rst pulse mid-CALC → all outputs 0, o_ready=1. rd=0 DIVU 9/3 → handshake completes, o_rd_wren stays 0.
